// File: rtl/gpu_param_pkg.sv
// Shared constants and types for the parameter double-buffer bank.
// Word offsets describe how downstream stages carve up the 27-word bank.
package gpu_param_pkg;

   localparam int NUM_BYTES = 54;
   localparam int NUM_WORDS = NUM_BYTES / 2;
   localparam int IDX_W     = 6;
   localparam int ADDR_W    = 5;

   // Commit state: ARMED means a complete packet waits for frame_start
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } dbuf_state_e;

   // Word offsets of packet fields (three vertices, 4x4 matrix, colour)
   localparam int WOFF_VTX0  = 0;
   localparam int WOFF_VTX1  = 3;
   localparam int WOFF_VTX2  = 6;
   localparam int WOFF_MAT   = 9;
   localparam int WOFF_COLOR = 25;

   // Packets are big-endian: lower byte index is the high half of a word
   function automatic logic [15:0] be_word(input logic [7:0] hi, input logic [7:0] lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/param_byte_regs.sv
// NUM_BYTES x 8 register array: one byte write port, a whole-array bulk
// load (takes priority over the byte write) and a big-endian word read port.
module param_byte_regs
   import gpu_param_pkg::*;
#(
   parameter int NUM_BYTES = gpu_param_pkg::NUM_BYTES,
   parameter int IDX_W     = gpu_param_pkg::IDX_W,
   parameter int ADDR_W    = gpu_param_pkg::ADDR_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       we,
   input  logic [IDX_W-1:0]           waddr,
   input  logic [7:0]                 wdata,
   input  logic                       load,
   input  logic [NUM_BYTES-1:0][7:0]  load_data,
   output logic [NUM_BYTES-1:0][7:0]  bytes_q,
   input  logic [ADDR_W-1:0]          raddr,
   output logic [15:0]                rword
);

   localparam int NUM_WORDS_L = NUM_BYTES / 2;

   // Byte storage; bulk load copies every byte in one cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         bytes_q <= '0;
      else if (load)
         bytes_q <= load_data;
      else if (we && (int'(waddr) < NUM_BYTES))
         bytes_q[waddr] <= wdata;
   end

   // Word read; addresses past the last word read as zero
   always_comb begin
      rword = '0;
      if (int'(raddr) < NUM_WORDS_L)
         rword = be_word(bytes_q[{raddr, 1'b0}], bytes_q[{raddr, 1'b1}]);
   end

endmodule

// File: rtl/param_dbuf_bank.sv
// Parameter double buffer: bytes from the packet assembler land in a shadow
// bank, which is copied to the active bank only on frame_start once a full
// packet is armed. Optional sequence checking: PARAM_DBUF_SEQCHECK_EN.
module param_dbuf_bank
   import gpu_param_pkg::*;
#(
   parameter int NUM_BYTES = gpu_param_pkg::NUM_BYTES,
   parameter int IDX_W     = gpu_param_pkg::IDX_W,
   parameter int ADDR_W    = gpu_param_pkg::ADDR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               update_reg,
   input  logic [IDX_W-1:0]   idx,
   input  logic [7:0]         read_data,
   input  logic               pc_ready,
   input  logic               frame_start,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [15:0]        rd_word,
   output logic               bank_valid,
   output logic               commit_pulse,
   output logic               pending,
   output logic               overrun,
   input  logic               overrun_clr
`ifdef PARAM_DBUF_SEQCHECK_EN
   ,output logic              seq_err
`endif
);

   dbuf_state_e               state;
   logic [NUM_BYTES-1:0][7:0] shadow_q;
   logic [NUM_BYTES-1:0][7:0] active_bytes_unused;
   logic [15:0]               shadow_word_unused;
   logic                      wr_ok, arm_req, commit, supersede;

`ifdef PARAM_DBUF_SEQCHECK_EN
   logic [IDX_W-1:0] exp_idx;
   logic             seq_block;
   logic             seq_set;

   // An out-of-order index poisons the packet until idx 0 restarts it
   always_comb begin
      seq_set = update_reg && (idx != '0) && (idx != exp_idx);
      arm_req = pc_ready && !seq_block;
   end

   // Expected-index tracking and sticky sequence error
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_idx   <= '0;
         seq_block <= 1'b0;
         seq_err   <= 1'b0;
      end else begin
         if (update_reg) begin
            exp_idx <= idx + 1'b1;
            if (idx == '0)
               seq_block <= 1'b0;
            else if (seq_set)
               seq_block <= 1'b1;
         end else if (pc_ready) begin
            exp_idx <= '0;
         end
         if (seq_set)
            seq_err <= 1'b1;
         else if (overrun_clr)
            seq_err <= 1'b0;
      end
   end
`else
   assign arm_req = pc_ready;
`endif

   // Commit on frame_start when armed, or when arming in the same cycle;
   // a new packet start while armed drops the waiting one unless a commit wins
   always_comb begin
      wr_ok     = update_reg && (int'(idx) < NUM_BYTES);
      commit    = frame_start && ((state == ST_ARMED) || arm_req);
      supersede = (state == ST_ARMED) && update_reg && (idx == '0) && !frame_start;
   end

   // Commit FSM with registered status outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         bank_valid   <= 1'b0;
         commit_pulse <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         commit_pulse <= commit;
         if (commit) begin
            state      <= ST_IDLE;
            bank_valid <= 1'b1;
         end else if (supersede) begin
            state <= ST_IDLE;
         end else if (arm_req) begin
            state <= ST_ARMED;
         end
         if (supersede)
            overrun <= 1'b1;
         else if (overrun_clr)
            overrun <= 1'b0;
      end
   end

   assign pending = (state == ST_ARMED);

   param_byte_regs #(.NUM_BYTES(NUM_BYTES), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) u_shadow (
      .clk       (clk),
      .reset     (reset),
      .we        (wr_ok),
      .waddr     (idx),
      .wdata     (read_data),
      .load      (1'b0),
      .load_data ('0),
      .bytes_q   (shadow_q),
      .raddr     ('0),
      .rword     (shadow_word_unused)
   );

   // Active bank copies the pre-write shadow, so a same-cycle byte write
   // stays in the shadow only
   param_byte_regs #(.NUM_BYTES(NUM_BYTES), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) u_active (
      .clk       (clk),
      .reset     (reset),
      .we        (1'b0),
      .waddr     ('0),
      .wdata     ('0),
      .load      (commit),
      .load_data (shadow_q),
      .bytes_q   (active_bytes_unused),
      .raddr     (rd_addr),
      .rword     (rd_word)
   );

endmodule

// File: doc/param_dbuf_bank.md
Name: param_dbuf_bank

Overview:
- Sits directly downstream of the UART packet assembler. Captures its 54-byte parameter stream (byte, index, write strobe, packet-done pulse) into a shadow bank.
- Commits the shadow bank to an active bank only at a frame boundary, so the rasteriser never sees a half-updated packet.
- Exposes the active bank as 27 big-endian 16-bit words through a combinational read port.

Parameters:
- NUM_BYTES, 54, bytes per packet; must be even.
- IDX_W, 6, width of the incoming byte index.
- ADDR_W, 5, width of the word read address; NUM_WORDS = NUM_BYTES/2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- update_reg  in  1  one-cycle byte-write strobe from the assembler.
- idx  in  IDX_W  byte index 0..NUM_BYTES-1, valid with update_reg.
- read_data  in  8  byte value, valid with update_reg.
- pc_ready  in  1  one-cycle pulse: packet complete.
- frame_start  in  1  one-cycle pulse at the start of a frame (vsync).
- rd_addr  in  ADDR_W  word read address.
- rd_word  out  16  active word, {active[2*rd_addr], active[2*rd_addr+1]}.
- bank_valid  out  1  high once at least one commit has occurred.
- commit_pulse  out  1  one cycle high in the cycle after a commit.
- pending  out  1  a complete packet is waiting for frame_start.
- overrun  out  1  sticky; an uncommitted packet was dropped.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (async assert, sync release) clears:
  - all shadow and active bytes to 0x00;
  - bank_valid, commit_pulse, pending and overrun to 0.
  - Reset mid-packet discards the partial packet; no commit follows.
- Shadow write: when update_reg=1 and idx<NUM_BYTES, shadow[idx] <= read_data. When idx>=NUM_BYTES, the write is ignored silently.
- States: IDLE (pending=0) and ARMED (pending=1).
- IDLE -> ARMED on pc_ready=1.
- ARMED -> IDLE on frame_start=1, which is a commit:
  - active <= shadow, all bytes in one cycle;
  - bank_valid <= 1;
  - commit_pulse=1 on the next cycle only.
- pc_ready and frame_start in the same cycle while IDLE: commit happens in that cycle. The last byte is always written at least one cycle before pc_ready.
- ARMED and update_reg with idx==0: the new packet supersedes the old one.
  - pending <= 0 and overrun <= 1.
  - The byte is written; no commit of the dropped packet.
- If frame_start coincides with that idx==0 write, the commit wins. The copy takes the pre-write shadow (register semantics), pending <= 0, overrun is unchanged.
- pc_ready while already ARMED keeps pending=1 and is not an overrun.
- frame_start while IDLE: no effect; active is held.
- overrun_clr clears overrun. A same-cycle set wins over the clear.
- rd_word is combinational from active. rd_addr>=NUM_WORDS returns 16'h0000.
- The shadow is never readable externally.

Optional Feature:
- Macro: PARAM_DBUF_SEQCHECK_EN.
- Defined:
  - An expected-index counter (IDX_W bits) resets to 0 on reset, on pc_ready, and on each update_reg with idx==0.
  - Any update_reg with idx != expected, idx!=0, sets sticky output seq_err (1 bit, cleared by overrun_clr). The counter resyncs to idx+1.
  - The next pc_ready is then ignored: no ARMED transition. The block stays ignoring until an idx==0 write restarts the sequence.
- Not defined: no seq_err port, no counter; every pc_ready arms.

Decomposition:
- Package gpu_param_pkg holds:
  - NUM_BYTES=54, NUM_WORDS=27, IDX_W=6, ADDR_W=5;
  - the IDLE/ARMED state encoding;
  - word-offset constants used by downstream stages for vertex and matrix fields.
- One natural sub-module, param_byte_regs: a NUM_BYTES x 8 register array with a byte write port, a bulk-load input and a word read port. It is instanced twice (shadow and active). The FSM, overrun and seq logic stay in the top.

Test Plan:
- Reset then write bytes 0x00..0x35 at idx 0..53, pc_ready, frame_start two cycles later:
  - commit_pulse one cycle after frame_start, bank_valid=1;
  - rd_addr=0 -> 0x0001, rd_addr=26 -> 0x3435, rd_addr=27 -> 0x0000.
- Full packet with pc_ready and no frame_start for 100 cycles -> pending=1, rd_word stays 0x0000. Then frame_start -> commit.
- Packet A armed, then packet B starts (idx 0, 0xAA) before frame_start:
  - overrun=1, pending=0;
  - later frame_start gives no commit_pulse;
  - B completes plus frame_start -> word 0 = 0xAAxx.
- pc_ready and frame_start in the same cycle, IDLE -> commit that cycle, commit_pulse next cycle.
- Assert reset at idx=20 -> all outputs 0; restart a full packet -> normal commit.
- SEQCHECK_EN: idx sequence 0,1,2,5 -> seq_err=1; following pc_ready not armed; frame_start gives no commit.
